// File: rtl/neuron_core_ctrl.sv
// neuron_core_ctrl: sequences AER event, time-step and sample-end sweeps over the neuron SRAMs and synapse array
module neuron_core_ctrl #(
  parameter int TIME_STEP                 = 8,
  parameter int INPUT_NEURON              = 784,
  parameter int OUTPUT_NEURON             = 256,
  parameter int POST_NEUR_PARALLEL        = 4,
  parameter int PRE_NEUR_ADDR_WIDTH       = 10,
  parameter int POST_NEUR_ADDR_WIDTH      = 10,
  parameter int POST_NEUR_BYTE_ADDR_WIDTH = 2,
  parameter int SYN_ARRAY_ADDR_WIDTH      = 16
) (
  input  logic                               CLK,
  input  logic                               RST_N,
  input  logic                               AER_REQ,
  input  logic [PRE_NEUR_ADDR_WIDTH-1:0]     AER_ADDR,
  output logic                               AER_ACK,
  input  logic                               TSTEP_REQ,
  input  logic                               TREF_REQ,
  input  logic                               SPI_GATE_ACTIVITY_sync,
  output logic [PRE_NEUR_ADDR_WIDTH-1:0]     CTRL_PRE_NEURON_ADDRESS,
  output logic [POST_NEUR_ADDR_WIDTH-1:0]    CTRL_POST_NEURON_ADDRESS,
  output logic                               CTRL_PRE_NEUR_CS,
  output logic                               CTRL_PRE_NEUR_WE,
  output logic                               CTRL_POST_NEUR_CS,
  output logic                               CTRL_POST_NEUR_WE,
  output logic                               CTRL_NEUR_EVENT,
  output logic                               CTRL_TSTEP_EVENT,
  output logic                               CTRL_TREF_EVENT,
  output logic                               CTRL_PRE_CNT_EN,
  output logic [$clog2(TIME_STEP)-1:0]       CURRENT_TIME_STEP,
  output logic                               SYNARRAY_CS,
  output logic [SYN_ARRAY_ADDR_WIDTH-1:0]    SYNARRAY_ADDR,
  output logic                               BUSY,
  output logic                               SAMPLE_DONE
);
  localparam int W  = OUTPUT_NEURON / POST_NEUR_PARALLEL;
  localparam int WW = $clog2(W);
  localparam int TW = $clog2(TIME_STEP);
  typedef enum logic [3:0] {
    IDLE, PRE_RD, PRE_WR, POST_RD, POST_WR, TS_RD, TS_WR,
    TR_POST_RD, TR_POST_WR, TR_PRE_RD, TR_PRE_WR
  } state_t;
  state_t state, nxt;
  logic [WW-1:0] w, nxt_w;
  logic [PRE_NEUR_ADDR_WIDTH-1:0] p, nxt_p, aer, nxt_aer;
  logic [SYN_ARRAY_ADDR_WIDTH-1:0] nxt_syn;
  logic [TW-1:0] nxt_ts;
  logic tref_pend, ts_pend, tref_any, ts_any, arb, start_tr, start_ts, ack, done, w_last, p_last;
  // a pulse arriving in the same cycle as arbitration competes immediately
  assign tref_any = tref_pend | TREF_REQ;
  assign ts_any   = ts_pend | TSTEP_REQ;
  assign arb      = state == IDLE && !SPI_GATE_ACTIVITY_sync;
  assign start_tr = arb && tref_any;
  assign start_ts = arb && !tref_any && ts_any;
  assign w_last   = w == WW'(W - 1);
  assign p_last   = p == PRE_NEUR_ADDR_WIDTH'(INPUT_NEURON - 1);
  always_comb begin
    nxt     = state;
    nxt_w   = w;
    nxt_p   = p;
    nxt_aer = aer;
    nxt_syn = SYNARRAY_ADDR;
    nxt_ts  = CURRENT_TIME_STEP;
    ack     = 1'b0;
    done    = 1'b0;
    case (state)
      IDLE: begin
        if (start_tr) begin
          nxt   = TR_POST_RD;
          nxt_w = '0;
        end else if (start_ts) begin
          nxt   = TS_RD;
          nxt_w = '0;
        end else if (arb && AER_REQ) begin
          nxt     = PRE_RD;
          nxt_aer = AER_ADDR;
          nxt_syn = SYN_ARRAY_ADDR_WIDTH'(AER_ADDR) * SYN_ARRAY_ADDR_WIDTH'(W);
          ack     = 1'b1;
        end
      end
      PRE_RD: nxt = PRE_WR;
      PRE_WR: begin
        nxt   = POST_RD;
        nxt_w = '0;
      end
      POST_RD: nxt = POST_WR;
      POST_WR: begin
        nxt     = w_last ? IDLE : POST_RD;
        nxt_w   = w_last ? '0 : w + 1'b1;
        nxt_syn = w_last ? SYNARRAY_ADDR : SYNARRAY_ADDR + 1'b1;
      end
      TS_RD: nxt = TS_WR;
      TS_WR: begin
        nxt    = w_last ? IDLE : TS_RD;
        nxt_w  = w_last ? '0 : w + 1'b1;
        nxt_ts = (!w_last || CURRENT_TIME_STEP == TW'(TIME_STEP - 1)) ? CURRENT_TIME_STEP
                                                                       : CURRENT_TIME_STEP + 1'b1;
      end
      TR_POST_RD: nxt = TR_POST_WR;
      TR_POST_WR: begin
        nxt   = w_last ? TR_PRE_RD : TR_POST_RD;
        nxt_w = w_last ? '0 : w + 1'b1;
        nxt_p = '0;
      end
      TR_PRE_RD: nxt = TR_PRE_WR;
      TR_PRE_WR: begin
        nxt    = p_last ? IDLE : TR_PRE_RD;
        nxt_p  = p_last ? '0 : p + 1'b1;
        nxt_ts = p_last ? '0 : CURRENT_TIME_STEP;
        done   = p_last;
      end
      default: nxt = IDLE;
    endcase
  end
  // outputs are decoded from the next state so they line up with the state register
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      state                    <= IDLE;
      w                        <= '0;
      p                        <= '0;
      aer                      <= '0;
      tref_pend                <= 1'b0;
      ts_pend                  <= 1'b0;
      AER_ACK                  <= 1'b0;
      SAMPLE_DONE              <= 1'b0;
      CURRENT_TIME_STEP        <= '0;
      SYNARRAY_ADDR            <= '0;
      SYNARRAY_CS              <= 1'b0;
      CTRL_PRE_NEURON_ADDRESS  <= '0;
      CTRL_POST_NEURON_ADDRESS <= '0;
      CTRL_PRE_NEUR_CS         <= 1'b0;
      CTRL_PRE_NEUR_WE         <= 1'b0;
      CTRL_POST_NEUR_CS        <= 1'b0;
      CTRL_POST_NEUR_WE        <= 1'b0;
      CTRL_NEUR_EVENT          <= 1'b0;
      CTRL_TSTEP_EVENT         <= 1'b0;
      CTRL_TREF_EVENT          <= 1'b0;
      CTRL_PRE_CNT_EN          <= 1'b0;
      BUSY                     <= 1'b0;
    end else begin
      state                    <= nxt;
      w                        <= nxt_w;
      p                        <= nxt_p;
      aer                      <= nxt_aer;
      tref_pend                <= tref_any && !start_tr;
      ts_pend                  <= ts_any && !start_ts;
      AER_ACK                  <= ack;
      SAMPLE_DONE              <= done;
      CURRENT_TIME_STEP        <= nxt_ts;
      SYNARRAY_ADDR            <= nxt_syn;
      SYNARRAY_CS              <= nxt == POST_RD;
      CTRL_PRE_NEURON_ADDRESS  <= (nxt inside {TR_PRE_RD, TR_PRE_WR}) ? nxt_p : nxt_aer;
      CTRL_POST_NEURON_ADDRESS <= POST_NEUR_ADDR_WIDTH'(nxt_w) << POST_NEUR_BYTE_ADDR_WIDTH;
      CTRL_PRE_NEUR_CS         <= nxt inside {PRE_RD, PRE_WR, TR_PRE_RD, TR_PRE_WR};
      CTRL_PRE_NEUR_WE         <= nxt inside {PRE_WR, TR_PRE_WR};
      CTRL_POST_NEUR_CS        <= nxt inside {POST_RD, POST_WR, TS_RD, TS_WR, TR_POST_RD, TR_POST_WR};
      CTRL_POST_NEUR_WE        <= nxt inside {POST_WR, TS_WR, TR_POST_WR};
      CTRL_NEUR_EVENT          <= nxt inside {PRE_WR, POST_WR};
      CTRL_TSTEP_EVENT         <= nxt == TS_WR;
      CTRL_TREF_EVENT          <= nxt inside {TR_POST_WR, TR_PRE_WR};
      CTRL_PRE_CNT_EN          <= nxt == PRE_WR;
      BUSY                     <= nxt != IDLE;
    end
  end
endmodule

// File: tb/tb_neuron_core_ctrl.sv
// tb_neuron_core_ctrl: directed scenario bench for neuron_core_ctrl with default parameters (W=64)
module tb_neuron_core_ctrl;
  logic CLK = 0, RST_N = 0, AER_REQ = 0, TSTEP_REQ = 0, TREF_REQ = 0, gate = 0;
  logic [9:0] AER_ADDR = '0;
  logic AER_ACK, pre_cs, pre_we, post_cs, post_we, neur_ev, tstep_ev, tref_ev, cnt_en;
  logic syn_cs, BUSY, SAMPLE_DONE;
  logic [9:0] pre_addr, post_addr;
  logic [2:0] step;
  logic [15:0] syn_addr;
  logic [50:0] all_out;
  int checks = 0, errors = 0;
  always #5 CLK = ~CLK;
  neuron_core_ctrl dut (
    .CLK(CLK), .RST_N(RST_N), .AER_REQ(AER_REQ), .AER_ADDR(AER_ADDR), .AER_ACK(AER_ACK),
    .TSTEP_REQ(TSTEP_REQ), .TREF_REQ(TREF_REQ), .SPI_GATE_ACTIVITY_sync(gate),
    .CTRL_PRE_NEURON_ADDRESS(pre_addr), .CTRL_POST_NEURON_ADDRESS(post_addr),
    .CTRL_PRE_NEUR_CS(pre_cs), .CTRL_PRE_NEUR_WE(pre_we), .CTRL_POST_NEUR_CS(post_cs),
    .CTRL_POST_NEUR_WE(post_we), .CTRL_NEUR_EVENT(neur_ev), .CTRL_TSTEP_EVENT(tstep_ev),
    .CTRL_TREF_EVENT(tref_ev), .CTRL_PRE_CNT_EN(cnt_en), .CURRENT_TIME_STEP(step),
    .SYNARRAY_CS(syn_cs), .SYNARRAY_ADDR(syn_addr), .BUSY(BUSY), .SAMPLE_DONE(SAMPLE_DONE)
  );
  assign all_out = {AER_ACK, pre_addr, post_addr, pre_cs, pre_we, post_cs, post_we, neur_ev,
                    tstep_ev, tref_ev, cnt_en, step, syn_cs, syn_addr, BUSY, SAMPLE_DONE};

  task automatic wait_idle(input string name);
    int n = 0;
    while (BUSY && n < 300) begin
      @(negedge CLK);
      n++;
    end
    checks++;
    if (BUSY !== 1'b0) begin errors++; $display("FAIL %s_idle: BUSY=%b want 0", name, BUSY); end
  endtask

  task automatic test_reset;
    RST_N = 0; AER_REQ = 1; TSTEP_REQ = 1; TREF_REQ = 1; AER_ADDR = 10'd5;
    repeat (3) @(negedge CLK);
    checks++;
    if (all_out !== '0) begin errors++; $display("FAIL reset_outputs: got %h want 0", all_out); end
    AER_REQ = 0; TSTEP_REQ = 0; TREF_REQ = 0; RST_N = 1;
    repeat (2) @(negedge CLK);
    checks++;
    if ({BUSY, step} !== 4'b0) begin errors++; $display("FAIL reset_release: busy=%b step=%0d want 0 0", BUSY, step); end
  endtask

  task automatic test_event;
    logic wr;
    int wi;
    AER_ADDR = 10'd5; AER_REQ = 1;
    @(negedge CLK);
    checks++;
    if ({AER_ACK, BUSY, pre_cs, pre_we, pre_addr} !== {4'b1110, 10'd5}) begin
      errors++; $display("FAIL event_accept: got %b want %b", {AER_ACK, BUSY, pre_cs, pre_we, pre_addr}, {4'b1110, 10'd5});
    end
    AER_REQ = 0;
    @(negedge CLK);
    checks++;
    if ({AER_ACK, pre_cs, pre_we, neur_ev, cnt_en, post_cs} !== 6'b011110) begin
      errors++; $display("FAIL event_pre_wr: got %b want 011110", {AER_ACK, pre_cs, pre_we, neur_ev, cnt_en, post_cs});
    end
    for (int i = 0; i < 128; i++) begin
      @(negedge CLK);
      wr = (i % 2) == 1;
      wi = i / 2;
      checks++;
      if ({BUSY, post_cs, post_we, syn_cs, neur_ev, pre_cs} !== {1'b1, 1'b1, wr, !wr, wr, 1'b0}) begin
        errors++; $display("FAIL event_post_ctrl[%0d]: got %b want %b", i, {BUSY, post_cs, post_we, syn_cs, neur_ev, pre_cs}, {1'b1, 1'b1, wr, !wr, wr, 1'b0});
      end
      checks++;
      if (post_addr !== 10'(wi * 4)) begin errors++; $display("FAIL event_post_addr[%0d]: got %0d want %0d", i, post_addr, wi * 4); end
      if (!wr) begin
        checks++;
        if (syn_addr !== 16'(320 + wi)) begin errors++; $display("FAIL event_syn_addr[%0d]: got %0d want %0d", i, syn_addr, 320 + wi); end
      end
    end
    @(negedge CLK);
    checks++;
    if ({BUSY, AER_ACK, neur_ev} !== 3'b000) begin errors++; $display("FAIL event_end: got %b want 000", {BUSY, AER_ACK, neur_ev}); end
  endtask

  task automatic test_tstep;
    logic wr;
    for (int n = 1; n <= 8; n++) begin
      TSTEP_REQ = 1;
      @(negedge CLK);
      TSTEP_REQ = 0;
      for (int i = 0; i < 128; i++) begin
        wr = (i % 2) == 1;
        checks++;
        if ({BUSY, post_cs, post_we, tstep_ev, syn_cs, neur_ev} !== {1'b1, 1'b1, wr, wr, 2'b00}) begin
          errors++; $display("FAIL tstep_ctrl[%0d.%0d]: got %b want %b", n, i, {BUSY, post_cs, post_we, tstep_ev, syn_cs, neur_ev}, {1'b1, 1'b1, wr, wr, 2'b00});
        end
        @(negedge CLK);
      end
      checks++;
      if ({BUSY, step} !== {1'b0, 3'(n < 7 ? n : 7)}) begin
        errors++; $display("FAIL tstep_step[%0d]: busy=%b step=%0d want 0 %0d", n, BUSY, step, n < 7 ? n : 7);
      end
    end
  endtask

  task automatic test_simultaneous;
    logic wr, pre;
    AER_ADDR = 10'd9; AER_REQ = 1; TREF_REQ = 1; TSTEP_REQ = 1;
    @(negedge CLK);
    TREF_REQ = 0; TSTEP_REQ = 0;
    for (int i = 0; i < 1696; i++) begin
      wr = (i % 2) == 1;
      pre = i >= 128;
      checks++;
      if ({BUSY, AER_ACK, SAMPLE_DONE, tref_ev, tstep_ev, post_cs, pre_cs} !== {3'b100, wr, 1'b0, !pre, pre}) begin
        errors++; $display("FAIL tref_ctrl[%0d]: got %b want %b", i, {BUSY, AER_ACK, SAMPLE_DONE, tref_ev, tstep_ev, post_cs, pre_cs}, {3'b100, wr, 1'b0, !pre, pre});
      end
      if (pre) begin
        checks++;
        if (pre_addr !== 10'((i - 128) / 2)) begin errors++; $display("FAIL tref_pre_addr[%0d]: got %0d want %0d", i, pre_addr, (i - 128) / 2); end
      end
      @(negedge CLK);
    end
    checks++;
    if ({BUSY, SAMPLE_DONE, AER_ACK, step} !== 6'b010000) begin
      errors++; $display("FAIL tref_done: got %b want 010000", {BUSY, SAMPLE_DONE, AER_ACK, step});
    end
    @(negedge CLK);
    for (int i = 0; i < 128; i++) begin
      wr = (i % 2) == 1;
      checks++;
      if ({BUSY, AER_ACK, SAMPLE_DONE, tstep_ev} !== {3'b100, wr}) begin
        errors++; $display("FAIL simul_tstep[%0d]: got %b want %b", i, {BUSY, AER_ACK, SAMPLE_DONE, tstep_ev}, {3'b100, wr});
      end
      @(negedge CLK);
    end
    checks++;
    if ({BUSY, AER_ACK, step} !== 5'b00001) begin errors++; $display("FAIL simul_gap: got %b want 00001", {BUSY, AER_ACK, step}); end
    @(negedge CLK);
    checks++;
    if ({AER_ACK, BUSY, pre_addr} !== {2'b11, 10'd9}) begin
      errors++; $display("FAIL simul_ack: got %b want %b", {AER_ACK, BUSY, pre_addr}, {2'b11, 10'd9});
    end
    AER_REQ = 0;
    wait_idle("simul");
  endtask

  task automatic test_gate;
    AER_ADDR = 10'd2; AER_REQ = 1;
    @(negedge CLK);
    checks++;
    if ({AER_ACK, BUSY} !== 2'b11) begin errors++; $display("FAIL gate_first_ack: got %b want 11", {AER_ACK, BUSY}); end
    AER_REQ = 0;
    for (int i = 1; i < 130; i++) begin
      @(negedge CLK);
      if (i == 5) begin gate = 1; AER_REQ = 1; AER_ADDR = 10'd3; end
      checks++;
      if ({BUSY, AER_ACK} !== 2'b10) begin errors++; $display("FAIL gate_sweep[%0d]: got %b want 10", i, {BUSY, AER_ACK}); end
    end
    for (int i = 0; i < 10; i++) begin
      @(negedge CLK);
      checks++;
      if ({BUSY, AER_ACK} !== 2'b00) begin errors++; $display("FAIL gate_hold[%0d]: got %b want 00", i, {BUSY, AER_ACK}); end
    end
    gate = 0;
    @(negedge CLK);
    checks++;
    if ({AER_ACK, BUSY, pre_addr} !== {2'b11, 10'd3}) begin
      errors++; $display("FAIL gate_release_ack: got %b want %b", {AER_ACK, BUSY, pre_addr}, {2'b11, 10'd3});
    end
    AER_REQ = 0;
    wait_idle("gate");
  endtask

  task automatic test_reset_mid;
    AER_ADDR = 10'd7; AER_REQ = 1;
    @(negedge CLK);
    checks++;
    if (AER_ACK !== 1'b1) begin errors++; $display("FAIL rstmid_ack: got %b want 1", AER_ACK); end
    AER_REQ = 0;
    for (int i = 1; i <= 62; i++) begin
      @(negedge CLK);
      if (i == 10) TSTEP_REQ = 1;
      if (i == 11) TSTEP_REQ = 0;
    end
    checks++;
    if ({syn_cs, post_addr, syn_addr} !== {1'b1, 10'd120, 16'd478}) begin
      errors++; $display("FAIL rstmid_w30: got cs=%b post=%0d syn=%0d want 1 120 478", syn_cs, post_addr, syn_addr);
    end
    RST_N = 0;
    #1;
    checks++;
    if (all_out !== '0) begin errors++; $display("FAIL rstmid_outputs: got %h want 0", all_out); end
    @(negedge CLK);
    RST_N = 1;
    @(negedge CLK);
    checks++;
    if ({BUSY, step} !== 4'b0) begin errors++; $display("FAIL rstmid_pending: busy=%b step=%0d want 0 0", BUSY, step); end
    AER_ADDR = 10'd1; AER_REQ = 1;
    @(negedge CLK);
    checks++;
    if ({AER_ACK, BUSY, pre_cs, post_cs, pre_addr} !== {4'b1110, 10'd1}) begin
      errors++; $display("FAIL rstmid_next_ack: got %b want %b", {AER_ACK, BUSY, pre_cs, post_cs, pre_addr}, {4'b1110, 10'd1});
    end
    AER_REQ = 0;
    repeat (2) @(negedge CLK);
    checks++;
    if ({syn_cs, syn_addr} !== {1'b1, 16'd64}) begin errors++; $display("FAIL rstmid_next_syn: got cs=%b syn=%0d want 1 64", syn_cs, syn_addr); end
    wait_idle("rstmid");
  endtask

  initial begin
    #1ms;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    test_reset;
    test_event;
    test_tstep;
    test_simultaneous;
    test_gate;
    test_reset_mid;
    $display("End of test - %0d assertions evaluated, %0d failures", checks, errors);
    $finish;
  end
endmodule
